// File: rtl/speck_pkg.sv
// SPECK iterative core: shared FSM encoding, rotate helpers
// and default rotation amounts per word width.
package speck_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEY_EXP,
      ST_READY,
      ST_CRYPT,
      ST_DONE
   } state_t;

   function automatic int unsigned def_alpha(input int unsigned w);
      return (w == 16) ? 7 : 8;
   endfunction

   function automatic int unsigned def_beta(input int unsigned w);
      return (w == 16) ? 2 : 3;
   endfunction

   function automatic logic [MAX_W-1:0] wmask(input int unsigned w);
      if (w >= MAX_W)
         return '1;
      return (MAX_W'(1) << w) - MAX_W'(1);
   endfunction

   // Rotates within the low w bits of a MAX_W container.
   function automatic logic [MAX_W-1:0] ror(
      input logic [MAX_W-1:0] v,
      input int unsigned      r,
      input int unsigned      w
   );
      logic [MAX_W-1:0] m;
      logic [MAX_W-1:0] t;
      m = wmask(w);
      t = v & m;
      return ((t >> r) | (t << (w - r))) & m;
   endfunction

   function automatic logic [MAX_W-1:0] rol(
      input logic [MAX_W-1:0] v,
      input int unsigned      r,
      input int unsigned      w
   );
      return ror(v, w - r, w);
   endfunction

endpackage

// File: rtl/speck_round.sv
// One SPECK round, encrypt or decrypt. The encrypt path doubles
// as the key-schedule step (l as a, k as b, round index as rk).
module speck_round
   import speck_pkg::*;
#(
   parameter int unsigned WORD_W = 64,
   parameter int unsigned ALPHA  = 8,
   parameter int unsigned BETA   = 3
) (
   input  logic              dec,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [WORD_W-1:0] rk,
   output logic [WORD_W-1:0] a_o,
   output logic [WORD_W-1:0] b_o
);

   always_comb begin
      a_o = '0;
      b_o = '0;
      if (dec) begin
         b_o = WORD_W'(ror(MAX_W'(a ^ b), BETA, WORD_W));
         a_o = WORD_W'(rol(MAX_W'((a ^ rk) - b_o), ALPHA, WORD_W));
      end else begin
         a_o = (WORD_W'(ror(MAX_W'(a), ALPHA, WORD_W)) + b) ^ rk;
         b_o = WORD_W'(rol(MAX_W'(b), BETA, WORD_W)) ^ a_o;
      end
   end

endmodule

// File: rtl/speck_iter_core.sv
// Iterative SPECK core: one-time key expansion into a round-key
// array, then one round per clock in either direction.
module speck_iter_core
   import speck_pkg::*;
#(
   parameter int unsigned WORD_W    = 64,
   parameter int unsigned KEY_WORDS = 2,
   parameter int unsigned NR_ROUNDS = 32,
   parameter int unsigned ALPHA     = def_alpha(WORD_W),
   parameter int unsigned BETA      = def_beta(WORD_W),
   localparam int unsigned KEY_W    = KEY_WORDS * WORD_W,
   localparam int unsigned BLK_W    = 2 * WORD_W,
   localparam int unsigned CW       = $clog2(NR_ROUNDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [KEY_W-1:0] key,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [BLK_W-1:0] in_block,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_block,
   output logic             key_loaded
);

   state_t state_q;
   state_t state_d;

   logic [CW-1:0]     ctr_q;
   logic [WORD_W-1:0] k_q;
   logic [WORD_W-1:0] l_q [KEY_WORDS-1];
   logic [WORD_W-1:0] x_q;
   logic [WORD_W-1:0] y_q;
   logic              mode_q;
   logic              loaded_q;
   logic [WORD_W-1:0] rk_mem [NR_ROUNDS];

   logic              rnd_dec;
   logic [WORD_W-1:0] rnd_a;
   logic [WORD_W-1:0] rnd_b;
   logic [WORD_W-1:0] rnd_rk;
   logic [WORD_W-1:0] rnd_a_o;
   logic [WORD_W-1:0] rnd_b_o;

   logic st_idle, st_kexp, st_ready, st_crypt, st_done;
   logic key_hs, blk_hs, out_hs;
   logic last_up, last_dn, crypt_last;

   assign st_idle  = (state_q == ST_IDLE);
   assign st_kexp  = (state_q == ST_KEY_EXP);
   assign st_ready = (state_q == ST_READY);
   assign st_crypt = (state_q == ST_CRYPT);
   assign st_done  = (state_q == ST_DONE);

   assign key_hs = key_valid && key_ready;
   assign blk_hs = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   assign last_up    = (ctr_q == CW'(NR_ROUNDS - 1));
   assign last_dn    = (ctr_q == '0);
   assign crypt_last = mode_q ? last_dn : last_up;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (key_hs) state_d = ST_KEY_EXP;
         ST_KEY_EXP:
            if (last_up) state_d = ST_READY;
         ST_READY:
            if (key_hs)      state_d = ST_KEY_EXP;
            else if (blk_hs) state_d = ST_CRYPT;
         ST_CRYPT:
            if (crypt_last) state_d = ST_DONE;
         ST_DONE:
            if (out_hs) state_d = ST_READY;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // A pending key outranks a block offered in the same READY cycle.
   always_comb begin
      key_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (1'b1)
         st_idle:  key_ready = 1'b1;
         st_ready: begin
            key_ready = 1'b1;
            in_ready  = !key_valid;
         end
         st_done:  out_valid = 1'b1;
         default:  ;
      endcase
   end

   always_comb begin
      if (st_kexp) begin
         rnd_a   = l_q[0];
         rnd_b   = k_q;
         rnd_rk  = WORD_W'(ctr_q);
         rnd_dec = 1'b0;
      end else begin
         rnd_a   = x_q;
         rnd_b   = y_q;
         rnd_rk  = rk_mem[ctr_q];
         rnd_dec = mode_q;
      end
   end

   speck_round #(
      .WORD_W (WORD_W),
      .ALPHA  (ALPHA),
      .BETA   (BETA)
   ) u_round (
      .dec (rnd_dec),
      .a   (rnd_a),
      .b   (rnd_b),
      .rk  (rnd_rk),
      .a_o (rnd_a_o),
      .b_o (rnd_b_o)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctr_q    <= '0;
         k_q      <= '0;
         l_q      <= '{default: '0};
         x_q      <= '0;
         y_q      <= '0;
         mode_q   <= 1'b0;
         loaded_q <= 1'b0;
      end else if (key_hs) begin
         k_q <= key[WORD_W-1:0];
         for (int j = 0; j < KEY_WORDS - 1; j++)
            l_q[j] <= key[(j+1)*WORD_W +: WORD_W];
         ctr_q    <= '0;
         loaded_q <= 1'b0;
      end else if (st_kexp) begin
         k_q <= rnd_b_o;
         for (int j = 0; j < KEY_WORDS - 2; j++)
            l_q[j] <= l_q[j+1];
         l_q[KEY_WORDS-2] <= rnd_a_o;
         if (last_up) begin
            ctr_q    <= '0;
            loaded_q <= 1'b1;
         end else begin
            ctr_q <= ctr_q + CW'(1);
         end
      end else if (blk_hs) begin
         x_q    <= in_block[BLK_W-1 -: WORD_W];
         y_q    <= in_block[WORD_W-1:0];
         mode_q <= in_mode;
         ctr_q  <= in_mode ? CW'(NR_ROUNDS - 1) : '0;
      end else if (st_crypt) begin
         x_q <= rnd_a_o;
         y_q <= rnd_b_o;
         // Hold the counter on the last round so decrypt stops at rk[0].
         if (!crypt_last)
            ctr_q <= mode_q ? ctr_q - CW'(1) : ctr_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (st_kexp)
         rk_mem[ctr_q] <= k_q;
   end

   assign out_block  = {x_q, y_q};
   assign key_loaded = loaded_q;

endmodule

// File: tb/tb_speck_iter_core.sv
// Directed bench for speck_iter_core: 128/128 and 32/64 instances
// driven in sequence from one shared clock and reset.
module tb_speck_iter_core;

   localparam logic [127:0] KA  = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] PA  = 128'h6c61766975716520_7469206564616d20;
   localparam logic [127:0] CA  = 128'ha65d985179783265_7860fedf5c570d18;
   localparam logic [127:0] KB  = 128'h1918_1110_0908_0100;
   localparam logic [127:0] PB  = 128'h6574_694c;
   localparam logic [127:0] CB  = 128'ha868_42f2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic         a_kv, a_kr, a_iv, a_ir, a_md, a_ov, a_or, a_kl;
   logic [127:0] a_key, a_in, a_out;

   logic         b_kv, b_kr, b_iv, b_ir, b_md, b_ov, b_or, b_kl;
   logic [63:0]  b_key;
   logic [31:0]  b_in, b_out;

   int total = 0;
   int bad   = 0;

   speck_iter_core #(
      .WORD_W(64), .KEY_WORDS(2), .NR_ROUNDS(32), .ALPHA(8), .BETA(3)
   ) dut_a (
      .clk(clk), .rst_n(rst_n),
      .key_valid(a_kv), .key_ready(a_kr), .key(a_key),
      .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_md), .in_block(a_in),
      .out_valid(a_ov), .out_ready(a_or), .out_block(a_out),
      .key_loaded(a_kl)
   );

   speck_iter_core #(
      .WORD_W(16), .KEY_WORDS(4), .NR_ROUNDS(22), .ALPHA(7), .BETA(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n),
      .key_valid(b_kv), .key_ready(b_kr), .key(b_key),
      .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_md), .in_block(b_in),
      .out_valid(b_ov), .out_ready(b_or), .out_block(b_out),
      .key_loaded(b_kl)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] outb(input bit s);
      return s ? 128'(b_out) : a_out;
   endfunction

   task automatic wait_kl(input bit s, input string tag);
      int n;
      n = 0;
      while (!(s ? b_kl : a_kl) && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_klat"}, 128'(n), s ? 128'd22 : 128'd32);
   endtask

   task automatic load_key(input bit s, input logic [127:0] k,
                           input string tag);
      chk({tag, "_kready"}, 128'(s ? b_kr : a_kr), 128'd1);
      if (s) begin
         b_kv = 1'b1; b_key = k[63:0];
      end else begin
         a_kv = 1'b1; a_key = k;
      end
      tick();
      a_kv = 1'b0;
      b_kv = 1'b0;
      chk({tag, "_kl_clr"}, 128'(s ? b_kl : a_kl), 128'd0);
      wait_kl(s, tag);
   endtask

   task automatic start(input bit s, input logic md, input logic [127:0] blk,
                        input string tag);
      chk({tag, "_irdy"}, 128'(s ? b_ir : a_ir), 128'd1);
      if (s) begin
         b_iv = 1'b1; b_md = md; b_in = blk[31:0];
      end else begin
         a_iv = 1'b1; a_md = md; a_in = blk;
      end
      tick();
      a_iv = 1'b0;
      b_iv = 1'b0;
   endtask

   task automatic wait_out(input bit s, input string tag);
      int lat;
      lat = 1;
      while (!(s ? b_ov : a_ov) && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 128'(lat), s ? 128'd23 : 128'd33);
   endtask

   task automatic pop(input bit s, input string tag);
      if (s) b_or = 1'b1; else a_or = 1'b1;
      tick();
      a_or = 1'b0;
      b_or = 1'b0;
      chk({tag, "_ov_clr"}, 128'(s ? b_ov : a_ov), 128'd0);
   endtask

   task automatic crypt(input bit s, input logic md, input logic [127:0] blk,
                        input logic [127:0] exp, input string tag);
      start(s, md, blk, tag);
      wait_out(s, tag);
      chk({tag, "_blk"}, outb(s), exp);
      pop(s, tag);
   endtask

   initial begin
      rst_n = 1'b0;
      a_kv = 0; a_key = '0; a_iv = 0; a_md = 0; a_in = '0; a_or = 0;
      b_kv = 0; b_key = '0; b_iv = 0; b_md = 0; b_in = '0; b_or = 0;
      tick();
      tick();
      chk("rst_kready", 128'(a_kr), 128'd1);
      chk("rst_iready", 128'(a_ir), 128'd0);
      chk("rst_ovalid", 128'(a_ov), 128'd0);
      chk("rst_oblock", a_out, 128'd0);
      chk("rst_kloaded", 128'(a_kl), 128'd0);
      rst_n = 1'b1;
      tick();

      load_key(0, KA, "a_key");
      crypt(0, 1'b0, PA, CA, "a_enc");
      crypt(0, 1'b1, CA, PA, "a_dec");

      start(0, 1'b0, PA, "a_stall");
      wait_out(0, "a_stall");
      for (int i = 0; i < 10; i++) begin
         chk("stall_blk", a_out, CA);
         chk("stall_ov", 128'(a_ov), 128'd1);
         chk("stall_ir", 128'(a_ir), 128'd0);
         chk("stall_kr", 128'(a_kr), 128'd0);
         tick();
      end
      pop(0, "a_stall");
      chk("stall_back_ready", 128'(a_ir), 128'd1);

      start(0, 1'b0, PA, "a_abort");
      for (int i = 0; i < 10; i++)
         tick();
      chk("abort_busy", 128'(a_kr), 128'd0);
      rst_n = 1'b0;
      tick();
      chk("abort_ov", 128'(a_ov), 128'd0);
      chk("abort_kl", 128'(a_kl), 128'd0);
      chk("abort_kr", 128'(a_kr), 128'd1);
      chk("abort_ir", 128'(a_ir), 128'd0);
      chk("abort_blk", a_out, 128'd0);
      rst_n = 1'b1;
      tick();
      load_key(0, KA, "a_rekey");
      crypt(0, 1'b0, PA, CA, "a_reenc");

      load_key(1, 128'd0, "b_key0");
      b_kv = 1'b1; b_key = KB[63:0];
      b_iv = 1'b1; b_md = 1'b0; b_in = PB[31:0];
      #1;
      chk("both_ir", 128'(b_ir), 128'd0);
      chk("both_kr", 128'(b_kr), 128'd1);
      @(posedge clk);
      #1;
      b_kv = 1'b0;
      b_iv = 1'b0;
      chk("both_kl_clr", 128'(b_kl), 128'd0);
      chk("both_kexp_kr", 128'(b_kr), 128'd0);
      wait_kl(1, "both");
      chk("both_no_blk", 128'(b_ov), 128'd0);
      crypt(1, 1'b0, PB, CB, "b_enc");
      crypt(1, 1'b1, CB, PB, "b_dec");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
